led_scan_mux: RTL and testbench

- Parametrised multiplexed 7-segment scan driver, the successor to the fixed 8-digit scanner.
- Scans N_DIG digits from a single clock using internal clock-enable ticks; no derived clocks.
- Displays a host-supplied frame of per-digit hex value, dot and blank bits, loaded through a valid/ready handshake. New frames take effect only at a frame boundary, so the display never tears.
- Adds PWM brightness control and configurable output polarity. Sits between the application datapath and the board's digit-select and segment pins.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_scan_timebase.sv | 48 ++++
 rtl/led_scan_mux.sv | 111 +++++++++++
 tb/tb_led_scan_mux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and the 7-segment decode table for the LED scan driver family.
package led_pkg;

  typedef struct packed {
    logic       blank;
    logic       dot;
    logic [3:0] hex;
  } digit_t;

  // Active-high {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    return SEG_LUT[hex];
  endfunction

endpackage

// File: rtl/led_scan_timebase.sv
// Scan timebase: subslot, PWM phase and digit pointer counters, all clock-enable based.
module led_scan_timebase #(
  parameter int unsigned F_CLK    = 50000000,
  parameter int unsigned F_SCAN   = 1000,
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned PWM_BITS = 3,
  localparam int unsigned PTR_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                sub_tick,
  output logic                slot_end,
  output logic                frame_end,
  output logic [PWM_BITS-1:0] pwm_ph,
  output logic [PTR_W-1:0]    dig_ptr
);

  localparam int unsigned SUB   = F_CLK / (F_SCAN * (2 ** PWM_BITS));
  localparam int unsigned SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  if (SUB < 2) begin : g_sub_check
    $error("led_scan_timebase: F_CLK/(F_SCAN*2^PWM_BITS) must be at least 2");
  end

  logic [SUB_W-1:0] sub_cnt;

  assign sub_tick  = (sub_cnt == SUB_W'(SUB - 1));
  assign slot_end  = sub_tick && (pwm_ph == '1);
  assign frame_end = slot_end && (dig_ptr == PTR_W'(N_DIG - 1));

  // pwm_ph spans a full power of two, so it wraps on its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      pwm_ph  <= '0;
      dig_ptr <= '0;
    end else begin
      sub_cnt <= sub_tick ? '0 : sub_cnt + SUB_W'(1);
      if (sub_tick) begin
        pwm_ph <= pwm_ph + PWM_BITS'(1);
      end
      if (slot_end) begin
        dig_ptr <= frame_end ? '0 : dig_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_scan_mux.sv
// Multiplexed 7-segment scan driver with frame handshake, tear-free frame swap,
// PWM brightness and configurable output polarity.
module led_scan_mux
  import led_pkg::*;
#(
  parameter int unsigned F_CLK       = 50000000,
  parameter int unsigned F_SCAN      = 1000,
  parameter int unsigned N_DIG       = 8,
  parameter int unsigned PWM_BITS    = 3,
  parameter bit          CS_ACT_LOW  = 1'b0,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_DIG*6-1:0]  in_frame,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_DIG-1:0]    cs,
  output logic [7:0]          seg,
  output logic                frame_tick
);

  localparam int unsigned          PTR_W       = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [N_DIG-1:0]     CS_OFF      = CS_ACT_LOW ? '1 : '0;
  localparam logic [7:0]           SEG_OFF     = SEG_ACT_LOW ? '1 : '0;
  localparam logic [N_DIG*6-1:0]   BLANK_FRAME = {N_DIG{6'b10_0000}};

  logic                sub_tick_unused;
  logic                slot_end;
  logic                frame_end;
  logic [PWM_BITS-1:0] pwm_ph;
  logic [PTR_W-1:0]    dig_ptr;

  led_scan_timebase #(
    .F_CLK   (F_CLK),
    .F_SCAN  (F_SCAN),
    .N_DIG   (N_DIG),
    .PWM_BITS(PWM_BITS)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .sub_tick (sub_tick_unused),
    .slot_end (slot_end),
    .frame_end(frame_end),
    .pwm_ph   (pwm_ph),
    .dig_ptr  (dig_ptr)
  );

  logic [N_DIG*6-1:0]  shadow;
  logic [N_DIG*6-1:0]  active;
  logic                shadow_full;
  logic [PWM_BITS-1:0] bri_q;

  assign in_ready = !shadow_full;

  // Swap and accept are exclusive: a swap needs a full shadow, an accept an empty one,
  // so a frame accepted on a frame-end cycle waits for the following frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      active      <= BLANK_FRAME;
    end else if (frame_end && shadow_full) begin
      active      <= shadow;
      shadow_full <= 1'b0;
    end else if (in_valid && !shadow_full) begin
      shadow      <= in_frame;
      shadow_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bri_q <= '0;
    end else if (slot_end) begin
      bri_q <= brightness;
    end
  end

  digit_t           cur;
  logic             lit;
  logic [N_DIG-1:0] cs_nxt;
  logic [7:0]       seg_nxt;

  always_comb begin
    cs_nxt  = '0;
    seg_nxt = '0;
    cur     = digit_t'(active[6 * int'(dig_ptr) +: 6]);
    lit     = (pwm_ph <= bri_q);
    if (lit) begin
      cs_nxt = N_DIG'(1) << dig_ptr;
      if (!cur.blank) begin
        seg_nxt = {cur.dot, seg_decode(cur.hex)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs         <= CS_OFF;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      cs         <= cs_nxt ^ CS_OFF;
      seg        <= seg_nxt ^ SEG_OFF;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux: 4 digits, 8-clock subslots, 32-clock slots, 128-clock frames.
module tb_led_scan_mux;

  localparam int S_CS   = 0;
  localparam int S_SEG  = 1;
  localparam int S_RDY  = 2;
  localparam int S_TICK = 3;
  localparam int S_CSI  = 4;
  localparam int S_SEGI = 5;
  localparam int S_RDYI = 6;
  localparam int S_TCKI = 7;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_frame = '0;
  logic [1:0]  brightness = 2'd3;

  logic       in_ready, frame_tick, in_ready_i, frame_tick_i;
  logic [3:0] cs, cs_i;
  logic [7:0] seg, seg_i;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  led_scan_mux #(
    .F_CLK(64), .F_SCAN(2), .N_DIG(4), .PWM_BITS(2), .CS_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_frame(in_frame),
    .brightness(brightness), .cs(cs), .seg(seg), .frame_tick(frame_tick)
  );

  led_scan_mux #(
    .F_CLK(64), .F_SCAN(2), .N_DIG(4), .PWM_BITS(2), .CS_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i), .in_frame(in_frame),
    .brightness(brightness), .cs(cs_i), .seg(seg_i), .frame_tick(frame_tick_i)
  );

  function automatic logic [7:0] pick(input int sig);
    case (sig)
      S_CS:    return {4'b0, cs};
      S_SEG:   return seg;
      S_RDY:   return {7'b0, in_ready};
      S_TICK:  return {7'b0, frame_tick};
      S_CSI:   return {4'b0, cs_i};
      S_SEGI:  return seg_i;
      S_RDYI:  return {7'b0, in_ready_i};
      default: return {7'b0, frame_tick_i};
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input logic [7:0] v, input string name);
    exp_t e;
    e.at = at; e.sig = sig; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        e = sb[i];
        sb.delete(i);
        n_checks++;
        act = pick(e.sig);
        if (e.at != cyc)
          $display("FAIL %s: expectation for cyc %0d missed (now cyc %0d)", e.name, e.at, cyc);
        else if (act !== e.exp)
          $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, act, e.exp);
        else
          n_pass++;
      end
    end
  end

  initial begin
    // Reset state, brightness held at 3 during reset
    expect_at(0, S_CS,   8'h00, "rst_cs");
    expect_at(0, S_SEG,  8'h00, "rst_seg");
    expect_at(0, S_RDY,  8'h01, "rst_ready");
    expect_at(0, S_TICK, 8'h00, "rst_tick");
    expect_at(0, S_CSI,  8'h0F, "rst_cs_inv");
    expect_at(0, S_SEGI, 8'hFF, "rst_seg_inv");
    // Blank frame: slot 0 uses reset bri_q=0, later slots brightness 3
    expect_at(8,   S_CS,   8'h01, "blank_slot0_lit");
    expect_at(9,   S_CS,   8'h00, "blank_slot0_dark");
    expect_at(9,   S_CSI,  8'h0F, "blank_dark_cs_inv");
    expect_at(9,   S_SEGI, 8'hFF, "blank_seg_inv");
    expect_at(33,  S_CS,   8'h02, "blank_slot1_lit");
    expect_at(64,  S_SEG,  8'h00, "blank_seg");
    expect_at(127, S_TICK, 8'h00, "tick_before");
    expect_at(128, S_TICK, 8'h01, "tick_frame1");
    expect_at(128, S_TCKI, 8'h01, "tick_frame1_inv");
    expect_at(129, S_TICK, 8'h00, "tick_one_cycle");
    expect_at(256, S_TICK, 8'h01, "tick_frame2");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame F1 {d3..d0} = {0x01, 0x12, 0x0A, 0x2F}
    at_cyc(200);
    in_valid = 1'b1;
    in_frame = {6'h01, 6'h12, 6'h0A, 6'h2F};
    expect_at(200, S_RDY,  8'h01, "f1_ready_before");
    expect_at(201, S_RDY,  8'h00, "f1_ready_drop");
    expect_at(201, S_RDYI, 8'h00, "f1_ready_drop_inv");
    expect_at(255, S_RDY,  8'h00, "f1_ready_held");
    expect_at(256, S_RDY,  8'h01, "f1_ready_rise");
    expect_at(256, S_SEG,  8'h00, "f1_not_yet_shown");
    expect_at(260, S_CS,   8'h01, "f1_d0_cs");
    expect_at(260, S_SEG,  8'h00, "f1_d0_blank");
    expect_at(290, S_SEG,  8'h77, "f1_d1_seg");
    expect_at(300, S_CSI,  8'h0D, "f1_d1_cs_inv");
    expect_at(300, S_SEGI, 8'h88, "f1_d1_seg_inv");
    expect_at(318, S_CS,   8'h02, "bri3_d1_full");
    at_cyc(201);
    in_valid = 1'b0;

    // Brightness 0 mid-slot d1: applies from slot d2
    at_cyc(300);
    brightness = 2'd0;
    expect_at(328, S_CS,  8'h04, "bri0_on");
    expect_at(328, S_SEG, 8'hDB, "f1_d2_seg");
    expect_at(329, S_CS,  8'h00, "bri0_off_cs");
    expect_at(329, S_SEG, 8'h00, "bri0_off_seg");
    // Brightness 1 mid-slot d2: phase 1 stays dark until slot d3
    at_cyc(325);
    brightness = 2'd1;
    expect_at(331, S_CS,  8'h00, "bri_midslot_hold");
    expect_at(368, S_CS,  8'h08, "bri1_ph1_on");
    expect_at(368, S_SEG, 8'h06, "f1_d3_seg");
    expect_at(369, S_CS,  8'h00, "bri1_ph2_off");
    at_cyc(370);
    brightness = 2'd3;

    // Frame A then B back to back; B waits for A to swap
    at_cyc(400);
    in_valid = 1'b1;
    in_frame = {6'h03, 6'h05, 6'h0C, 6'h18};
    expect_at(450, S_RDY,  8'h00, "ab_ready_low");
    expect_at(512, S_RDY,  8'h01, "ab_ready_swap");
    expect_at(512, S_SEG,  8'h06, "ab_old_frame_last");
    expect_at(512, S_CS,   8'h08, "ab_old_frame_cs");
    expect_at(513, S_RDY,  8'h00, "b_accepted");
    expect_at(520, S_CS,   8'h01, "a_d0_cs");
    expect_at(520, S_SEG,  8'hFF, "a_d0_eight_dot");
    expect_at(520, S_CSI,  8'h0E, "a_d0_cs_inv");
    expect_at(520, S_SEGI, 8'h00, "a_d0_seg_inv");
    expect_at(560, S_SEG,  8'h39, "a_d1_seg");
    expect_at(600, S_SEG,  8'h6D, "a_d2_seg");
    expect_at(640, S_SEG,  8'h4F, "a_d3_last");
    expect_at(640, S_TICK, 8'h01, "tick_frame5");
    expect_at(641, S_SEG,  8'h3F, "b_d0_first");
    expect_at(700, S_SEG,  8'h7C, "b_d1_seg");
    expect_at(720, S_SEG,  8'h5E, "b_d2_seg");
    expect_at(740, S_SEG,  8'h79, "b_d3_seg");
    at_cyc(401);
    in_frame = {6'h0E, 6'h0D, 6'h0B, 6'h00};
    at_cyc(513);
    in_valid = 1'b0;

    // Frame C accepted on the frame-end cycle: shown one frame later
    at_cyc(767);
    in_valid = 1'b1;
    in_frame = {6'h07, 6'h06, 6'h04, 6'h09};
    expect_at(767, S_RDY,  8'h01, "c_ready_at_end");
    expect_at(768, S_RDY,  8'h00, "c_accepted");
    expect_at(768, S_TICK, 8'h01, "c_tick");
    expect_at(770, S_SEG,  8'h3F, "c_b_still_shown");
    expect_at(895, S_RDY,  8'h00, "c_ready_held");
    expect_at(896, S_RDY,  8'h01, "c_ready_rise");
    expect_at(896, S_TICK, 8'h01, "c_tick_next");
    expect_at(896, S_SEG,  8'h79, "c_b_last");
    expect_at(900, S_SEG,  8'h6F, "c_d0_seg");
    expect_at(960, S_SEG,  8'h66, "c_d1_seg");
    expect_at(1000, S_SEG, 8'h07, "c_d3_seg");
    expect_at(1000, S_CS,  8'h08, "c_d3_cs");
    at_cyc(768);
    in_valid = 1'b0;

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    #1;
    while (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s: cyc %0d never sampled (timeout), expected %h", sb[0].name, sb[0].at, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
